cla_adder: RTL and testbench

- Registered carry-lookahead adder: computes {cout, sum} = a + b + cin using generate/propagate lookahead logic instead of ripple carry.
- Generic arithmetic leaf block for datapaths that need a fast, fixed-latency add with carry-in/carry-out.
- Combinational lookahead core followed by one output register stage.
- Valid strobe travels alongside the data.

---
 rtl/cla_pkg.sv | 12 +
 rtl/cla4_group.sv | 33 +++
 rtl/cla_adder.sv | 115 +++++++++++
 tb/tb_cla_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package cla_pkg;

    // Width of one lookahead group.
    localparam int CLA_GROUP_W = 4;

    // Number of 4-bit groups in a word of the given width.
    function automatic int cla_num_groups(input int width);
        return width / CLA_GROUP_W;
    endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group.
// Outputs the sum bits plus the group propagate/generate for the next lookahead level.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       grp_p,
    output logic       grp_g
);

    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [3:0] c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Each internal carry is fully expanded from g/p/cin, so no carry ripples.
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);

    assign s = p_s ^ c_s;

    // The group generate is independent of cin, so the upper level can use it directly.
    assign grp_p = &p_s;
    assign grp_g = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                 | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);

endmodule

// File: rtl/cla_adder.sv
// Registered carry-lookahead adder: {cout, sum} = a + b + cin, one cycle latency.
// 4-bit lookahead groups feed a second-level lookahead unit that produces
// each group's carry-in; results are captured only when in_valid is high.
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int NG = cla_num_groups(WIDTH);

    if (((WIDTH % CLA_GROUP_W) != 0) || (WIDTH < CLA_GROUP_W)) begin : g_bad_width
        $fatal(1, "cla_adder: WIDTH must be a positive multiple of 4");
    end

    logic [NG-1:0]    gp_s;
    logic [NG-1:0]    gg_s;
    logic [NG:0]      gc_s;
    logic [WIDTH-1:0] sum_s;
    logic             word_p_s;
    logic             word_g_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             grp_p_r;
    logic             grp_g_r;

    // Carry into group k, expanded as a sum of products over group P/G (no ripple):
    // c[k] = G[k-1] | P[k-1]G[k-2] | ... | P[k-1..0]c0
    function automatic logic carry_into(input logic [NG-1:0] p,
                                        input logic [NG-1:0] g,
                                        input logic          c0,
                                        input int            k);
        logic acc_v;
        logic prod_v;
        acc_v = c0;
        for (int j = 0; j < k; j++) begin
            acc_v = acc_v & p[j];
        end
        for (int j = 0; j < k; j++) begin
            prod_v = g[j];
            for (int m = j + 1; m < k; m++) begin
                prod_v = prod_v & p[m];
            end
            acc_v = acc_v | prod_v;
        end
        return acc_v;
    endfunction

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla4_group u_grp (
            .a     (a[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .b     (b[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .cin   (gc_s[gi]),
            .s     (sum_s[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .grp_p (gp_s[gi]),
            .grp_g (gg_s[gi])
        );
    end

    // Second-level lookahead: group carry-ins and whole-word propagate/generate.
    always_comb begin
        gc_s    = '0;
        gc_s[0] = cin;
        for (int k = 1; k <= NG; k++) begin
            gc_s[k] = carry_into(gp_s, gg_s, cin, k);
        end
        word_p_s = &gp_s;
        word_g_s = carry_into(gp_s, gg_s, 1'b0, NG);
    end

    // Output register stage: capture on in_valid, otherwise hold; valid is a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            grp_p_r     <= 1'b0;
            grp_g_r     <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                sum_r   <= sum_s;
                cout_r  <= gc_s[NG];
                grp_p_r <= word_p_s;
                grp_g_r <= word_g_s;
            end else begin
                sum_r   <= sum_r;
                cout_r  <= cout_r;
                grp_p_r <= grp_p_r;
                grp_g_r <= grp_g_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign grp_p     = grp_p_r;
    assign grp_g     = grp_g_r;

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder at WIDTH=4 and WIDTH=16.
// The driver pushes reference results tagged with the cycle they must appear in;
// a monitor compares on every falling edge (result, hold, or reset values).
module tb_cla_adder;

    typedef struct {
        int          due;
        logic [18:0] v;   // {grp_p, grp_g, cout, sum[15:0]}
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  a4, b4, sum4;
    logic [15:0] a16, b16, sum16;
    logic        cin4, cin16;
    logic        ov4, cout4, gp4, gg4;
    logic        ov16, cout16, gp16, gg16;

    int          cyc;
    int          checks;
    int          errors;
    exp_t        q4[$];
    exp_t        q16[$];
    logic [18:0] last4, last16;
    logic [19:0] act4, act16;

    cla_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .sum(sum4), .cout(cout4), .grp_p(gp4), .grp_g(gg4)
    );

    cla_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .sum(sum16), .cout(cout16), .grp_p(gp16), .grp_g(gg16)
    );

    assign act4  = {ov4, gp4, gg4, cout4, 12'h000, sum4};
    assign act16 = {ov16, gp16, gg16, cout16, sum16};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer addition over w bits.
    function automatic logic [18:0] model(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic c);
        logic [16:0] full;
        logic [16:0] nocin;
        logic [16:0] mask;
        logic [15:0] s;
        logic        pp;
        mask  = (17'd1 << w) - 17'd1;
        full  = {1'b0, x} + {1'b0, y} + {16'd0, c};
        nocin = {1'b0, x} + {1'b0, y};
        s     = full[15:0] & mask[15:0];
        pp    = (((x ^ y) & mask[15:0]) == mask[15:0]);
        return {pp, nocin[w], full[w], s};
    endfunction

    task automatic check(input string nm, input logic [19:0] exp, input logic [19:0] act);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] x4, input logic [3:0] y4, input logic c4,
                        input logic [15:0] x16, input logic [15:0] y16, input logic c16);
        exp_t e;
        @(posedge clk);
        #1;
        a4 = x4; b4 = y4; cin4 = c4;
        a16 = x16; b16 = y16; cin16 = c16;
        in_valid = 1'b1;
        e.due = cyc + 1;
        e.v = model(4, {12'h000, x4}, {12'h000, y4}, c4);
        q4.push_back(e);
        e.v = model(16, x16, y16, c16);
        q16.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        end
    endtask

    // Monitor: every falling edge expects either the due result, held values, or reset values.
    initial begin
        exp_t e;
        last4 = '0;
        last16 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q4.delete();
                q16.delete();
                last4 = '0;
                last16 = '0;
                check("reset_w4", 20'h00000, act4);
                check("reset_w16", 20'h00000, act16);
            end else begin
                if (q4.size() > 0 && q4[0].due == cyc) begin
                    e = q4.pop_front();
                    check("result_w4", {1'b1, e.v}, act4);
                    last4 = e.v;
                end else begin
                    check("hold_w4", {1'b0, last4}, act4);
                end
                if (q16.size() > 0 && q16[0].due == cyc) begin
                    e = q16.pop_front();
                    check("result_w16", {1'b1, e.v}, act16);
                    last16 = e.v;
                end else begin
                    check("hold_w16", {1'b0, last16}, act16);
                end
            end
        end
    end

    // Driver: directed vectors, hold/pulse, reset mid-run, then random back-to-back.
    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Basic and all-propagate vectors at WIDTH=4, with group-boundary cases at WIDTH=16.
        send(4'b0001, 4'b0000, 1'b0, 16'h00FF, 16'h0001, 1'b0);
        send(4'b0010, 4'b0100, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        send(4'b1011, 4'b0110, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        send(4'b0101, 4'b0011, 1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
        send(4'b1111, 4'b0000, 1'b1, 16'h8000, 16'h8000, 1'b0);
        send(4'b1111, 4'b1111, 1'b1, 16'h0FFF, 16'h0001, 1'b0);

        // Idle with changing operands, then a single pulse.
        idle(4);
        send(4'b0111, 4'b0001, 1'b0, 16'h1234, 16'h4321, 1'b1);
        idle(4);

        // Reset while a result is on the outputs: it must vanish at once.
        send(4'b1001, 4'b0110, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("midrst_valid_before", 20'h00001, {19'd0, ov4});
        rst_n = 1'b0;
        #1;
        check("midrst_w4", 20'h00000, act4);
        check("midrst_w16", 20'h00000, act16);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Random back-to-back stream.
        for (int i = 0; i < 1000; i++) begin
            send(4'($urandom), 4'($urandom), 1'($urandom),
                 16'($urandom), 16'($urandom), 1'($urandom));
        end
        idle(4);

        check("drain_w4", 20'h00000, 20'(q4.size()));
        check("drain_w16", 20'h00000, 20'(q16.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
